hazard_control_unit: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Each cycle it inspects the decode and execute stages, the branch outcome, and the data-memory busy flag. It drives the PC write enable, the IF/ID write enable, and the IF/ID, ID/EX and EX/MEM flush lines. A small FSM supports multi-cycle load-use stalls, and two saturating counters provide stall and flush statistics.

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/hazard_control_unit_if.sv | 36 +++
 rtl/hazard_control_unit_sat_counter.sv | 18 +
 rtl/hazard_control_unit.sv | 113 +++++++++++
 tb/tb_hazard_control_unit.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline control types, widths and hazard helper
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W    = 5;
    localparam int DEFAULT_CNT_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } pipe_state_e;

    // Load-use hazard: a load in ID/EX writes a register the IF/ID instruction reads; x0 is never a hazard
    function automatic logic load_use_hazard(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side signal bundle of the hazard control unit
interface hazard_control_unit_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);
    logic [REG_ADDR_W-1:0] IF_ID_rs1;
    logic [REG_ADDR_W-1:0] IF_ID_rs2;
    logic [REG_ADDR_W-1:0] ID_EX_rd;
    logic                  ID_EX_MemRead;
    logic                  Branch_Taken;
    logic                  Mem_Busy;
    logic                  PC_Write;
    logic                  IF_ID_Write;
    logic                  IF_ID_Flush;
    logic                  ID_EX_Flush;
    logic                  EX_MEM_Flush;
    logic                  Freeze;
    logic [1:0]            State;
    logic [CNT_W-1:0]      Stall_Count;
    logic [CNT_W-1:0]      Flush_Count;

    // Pipeline side: supplies stage information, consumes control lines
    modport master (
        output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead, Branch_Taken, Mem_Busy,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze,
        input  State, Stall_Count, Flush_Count
    );

    // Hazard unit side
    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_MemRead, Branch_Taken, Mem_Busy,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze,
        output State, Stall_Count, Flush_Count
    );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// rtl/hazard_control_unit_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    // Count increment events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/freeze sequencer for the 5-stage pipeline
module hazard_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = DEFAULT_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_control_unit_if.slave  bus
);
    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_STALL  = STALL;
    localparam logic [1:0] S_FREEZE = FREEZE;
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] saved_state_q, saved_state_d;
    logic [3:0] saved_cnt_q, saved_cnt_d;

    // While frozen the unit behaves as the state it was in before the freeze
    logic [1:0] eff_state;
    logic [3:0] eff_cnt;
    logic       hz;
    logic       stall_inc;
    logic       flush_inc;

    assign eff_state = (state_q == S_FREEZE) ? saved_state_q : state_q;
    assign eff_cnt   = (state_q == S_FREEZE) ? saved_cnt_q   : cnt_q;
    assign hz        = load_use_hazard(bus.ID_EX_MemRead, bus.ID_EX_rd, bus.IF_ID_rs1, bus.IF_ID_rs2);

    // Prioritised decode of control lines and next state: reset, freeze, branch flush, load-use bubble
    always_comb begin
        bus.PC_Write     = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.IF_ID_Flush  = 1'b0;
        bus.ID_EX_Flush  = 1'b0;
        bus.EX_MEM_Flush = 1'b0;
        bus.Freeze       = 1'b0;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        state_d          = S_RUN;
        cnt_d            = 4'd0;
        saved_state_d    = saved_state_q;
        saved_cnt_d      = saved_cnt_q;
        if (reset) begin
            bus.PC_Write     = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
        end else if (bus.Mem_Busy) begin
            bus.Freeze      = 1'b1;
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            state_d         = S_FREEZE;
            cnt_d           = eff_cnt;
            saved_state_d   = eff_state;
            saved_cnt_d     = eff_cnt;
        end else if (bus.Branch_Taken) begin
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Flush  = 1'b1;
            bus.EX_MEM_Flush = 1'b1;
            flush_inc        = 1'b1;
        end else if ((eff_state == S_STALL) || ((eff_state == S_RUN) && hz)) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.ID_EX_Flush = 1'b1;
            stall_inc       = 1'b1;
            if (eff_state == S_STALL) begin
                if (eff_cnt > 4'd1) begin
                    state_d = S_STALL;
                    cnt_d   = eff_cnt - 4'd1;
                end
            end else if (STALL_RELOAD != 4'd0) begin
                state_d = S_STALL;
                cnt_d   = STALL_RELOAD;
            end
        end
    end

    // FSM state, remaining bubble count and the context saved across a freeze
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_RUN;
            cnt_q         <= 4'd0;
            saved_state_q <= S_RUN;
            saved_cnt_q   <= 4'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            saved_state_q <= saved_state_d;
            saved_cnt_q   <= saved_cnt_d;
        end
    end

    assign bus.State = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (bus.Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (bus.Flush_Count)
    );
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, br, busy;

    int checks   = 0;
    int failures = 0;

    int nval[2] = '{1, 3};
    int rem[2];
    bit frozen[2];
    int scnt[2];
    int fcnt[2];

    logic [5:0]    out_v[2];
    logic [1:0]    st_v[2];
    logic [CW-1:0] sc_v[2];
    logic [CW-1:0] fc_v[2];

    hazard_control_unit_if #(.CNT_W(CW)) bus1 ();
    hazard_control_unit_if #(.CNT_W(CW)) bus3 ();

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(CW)) dut1 (.clk(clk), .reset(rst), .bus(bus1));
    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(CW)) dut3 (.clk(clk), .reset(rst), .bus(bus3));

    always #5 clk = ~clk;

    assign bus1.IF_ID_rs1 = rs1;
    assign bus1.IF_ID_rs2 = rs2;
    assign bus1.ID_EX_rd = rd;
    assign bus1.ID_EX_MemRead = mr;
    assign bus1.Branch_Taken = br;
    assign bus1.Mem_Busy = busy;
    assign bus3.IF_ID_rs1 = rs1;
    assign bus3.IF_ID_rs2 = rs2;
    assign bus3.ID_EX_rd = rd;
    assign bus3.ID_EX_MemRead = mr;
    assign bus3.Branch_Taken = br;
    assign bus3.Mem_Busy = busy;

    assign out_v[0] = {bus1.PC_Write, bus1.IF_ID_Write, bus1.IF_ID_Flush, bus1.ID_EX_Flush, bus1.EX_MEM_Flush, bus1.Freeze};
    assign out_v[1] = {bus3.PC_Write, bus3.IF_ID_Write, bus3.IF_ID_Flush, bus3.ID_EX_Flush, bus3.EX_MEM_Flush, bus3.Freeze};
    assign st_v[0] = bus1.State;
    assign st_v[1] = bus3.State;
    assign sc_v[0] = bus1.Stall_Count;
    assign sc_v[1] = bus3.Stall_Count;
    assign fc_v[0] = bus1.Flush_Count;
    assign fc_v[1] = bus3.Flush_Count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hazard();
        return mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    endfunction

    // Expected {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze}
    function automatic logic [5:0] exp_out(input int d);
        if (rst)                       return 6'b001110;
        if (busy)                      return 6'b000001;
        if (br)                        return 6'b111110;
        if (rem[d] > 0 || hazard())    return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic model_update(input int d);
        bit hz_now;
        hz_now = hazard();
        if (rst) begin
            rem[d] = 0; frozen[d] = 0; scnt[d] = 0; fcnt[d] = 0;
        end else if (busy) begin
            frozen[d] = 1;
        end else if (br) begin
            frozen[d] = 0;
            rem[d] = 0;
            if (fcnt[d] < CMAX) fcnt[d]++;
        end else if (rem[d] > 0 || hz_now) begin
            frozen[d] = 0;
            if (scnt[d] < CMAX) scnt[d]++;
            rem[d] = (rem[d] > 0) ? rem[d] - 1 : nval[d] - 1;
        end else begin
            frozen[d] = 0;
        end
    endtask

    task automatic step(input logic r, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d_rd,
                        input logic m, input logic b, input logic bz);
        int st;
        @(negedge clk);
        rst = r; rs1 = a1; rs2 = a2; rd = d_rd; mr = m; br = b; busy = bz;
        #1;
        for (int d = 0; d < 2; d++)
            check_eq($sformatf("n%0d_ctrl", nval[d]), 32'(out_v[d]), 32'(exp_out(d)));
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_update(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            st = frozen[d] ? 2 : (rem[d] > 0 ? 1 : 0);
            check_eq($sformatf("n%0d_state", nval[d]), 32'(st_v[d]), 32'(st));
            check_eq($sformatf("n%0d_stall_cnt", nval[d]), 32'(sc_v[d]), 32'(scnt[d]));
            check_eq($sformatf("n%0d_flush_cnt", nval[d]), 32'(fc_v[d]), 32'(fcnt[d]));
        end
    endtask

    task automatic idle();
        step(0, 5'd1, 5'd2, 5'd0, 0, 0, 0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; frozen[d] = 0; scnt[d] = 0; fcnt[d] = 0;
        end
        rst = 1; rs1 = 0; rs2 = 0; rd = 0; mr = 0; br = 0; busy = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();

        // Load x5 then add x6,x5,x1
        step(0, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        repeat (4) idle();

        // x0 destination never stalls
        step(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        idle();

        // Branch in the second bubble
        step(0, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        step(0, 5'd5, 5'd1, 5'd5, 1, 1, 0);
        repeat (3) idle();

        // Freeze in the middle of a stall with two bubbles left
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        repeat (4) step(0, 5'd5, 5'd1, 5'd5, 1, 0, 1);
        repeat (4) idle();

        // Flush counter saturation, then reset during a stall
        repeat (CMAX + 3) step(0, 5'd1, 5'd2, 5'd0, 0, 1, 0);
        step(0, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        step(1, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        idle();

        // Random traffic with a small register range to provoke hazards often
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 15));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
